// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 32,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_memread,
    input  logic [REG_AW-1:0] EX_rt,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              branch_taken,
    input  logic              mc_start,
    input  logic              mc_done,
    output logic              PCwrite,
    output logic              IF_IDwrite,
    output logic              IF_IDflush,
    output logic              ID_EXbubble,
    output logic              EX_hold,
    output logic              EX_MEMbubble,
    output logic              hazard,
    output logic              mc_error,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int TW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_MC_BUSY} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [FW-1:0]    r_flush_cnt;
    logic [FW-1:0]    w_flush_cnt_next;
    logic [TW-1:0]    r_to_cnt;
    logic [TW-1:0]    w_to_cnt_next;
    logic             r_mc_error;
    logic             w_set_error;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;

    assign w_load_use = EX_memread & ((EX_rt == ID_rs) | (EX_rt == ID_rt));
    assign mc_error   = r_mc_error;
    assign stall_cnt  = r_stall_cnt;

    always_comb begin
        PCwrite          = 1'b1;
        IF_IDwrite       = 1'b1;
        IF_IDflush       = 1'b0;
        ID_EXbubble      = 1'b0;
        EX_hold          = 1'b0;
        EX_MEMbubble     = 1'b0;
        hazard           = 1'b0;
        w_next_state     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        w_to_cnt_next    = r_to_cnt;
        w_set_error      = 1'b0;

        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    IF_IDflush  = 1'b1;
                    ID_EXbubble = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        w_next_state     = S_FLUSH;
                        w_flush_cnt_next = FW'(FLUSH_CYCLES - 1);
                    end
                end else if (mc_start) begin
                    EX_hold       = 1'b1;
                    EX_MEMbubble  = 1'b1;
                    PCwrite       = 1'b0;
                    IF_IDwrite    = 1'b0;
                    w_next_state  = S_MC_BUSY;
                    w_to_cnt_next = '0;
                end else if (w_load_use) begin
                    hazard      = 1'b1;
                    PCwrite     = 1'b0;
                    IF_IDwrite  = 1'b0;
                    ID_EXbubble = 1'b1;
                end
            end
            S_FLUSH: begin
                IF_IDflush  = 1'b1;
                ID_EXbubble = 1'b1;
                if (r_flush_cnt <= FW'(1)) begin
                    w_next_state = S_RUN;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - FW'(1);
                end
            end
            S_MC_BUSY: begin
                // mc_done is checked first so a coincident timeout never flags an error
                if (mc_done) begin
                    w_next_state = S_RUN;
                end else if (r_to_cnt == TW'(MC_TIMEOUT - 1)) begin
                    w_next_state = S_RUN;
                    w_set_error  = 1'b1;
                end else begin
                    EX_hold       = 1'b1;
                    EX_MEMbubble  = 1'b1;
                    PCwrite       = 1'b0;
                    IF_IDwrite    = 1'b0;
                    w_to_cnt_next = r_to_cnt + TW'(1);
                end
            end
            default: w_next_state = S_RUN;
        endcase

        if (rst) begin
            PCwrite      = 1'b0;
            IF_IDwrite   = 1'b0;
            IF_IDflush   = 1'b1;
            ID_EXbubble  = 1'b1;
            EX_hold      = 1'b0;
            EX_MEMbubble = 1'b1;
            hazard       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= '0;
            r_to_cnt    <= '0;
            r_mc_error  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_flush_cnt_next;
            r_to_cnt    <= w_to_cnt_next;
            if (w_set_error) begin
                r_mc_error <= 1'b1;
            end
            if (!PCwrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline of the 19-bit CPU.
- Combines three hazard sources into one registered state machine that drives all pipeline-register write enables, flushes and bubbles:
  - load-use hazards (EX load vs. ID source registers);
  - taken branches resolved in EX;
  - multi-cycle EX operations (mul/div) with a done handshake.
- Sits between the ID/EX/MEM stage logic and the PC, IF/ID, ID/EX and EX/MEM registers. Also keeps a stall-cycle performance counter.

Parameters:
- REG_AW, 3, register address width (8 GPRs; R0 is an ordinary register, not hardwired zero).
- FLUSH_CYCLES, 2, number of cycles IF/ID is flushed after a taken branch (≥1).
- MC_TIMEOUT, 32, maximum MC_BUSY cycles before the error exit.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- EX_memread  in  1  instruction in EX is a load.
- EX_rt  in  REG_AW  load destination in EX.
- ID_rs  in  REG_AW  ID source register 1.
- ID_rt  in  REG_AW  ID source register 2.
- branch_taken  in  1  branch in EX resolved taken this cycle.
- mc_start  in  1  multi-cycle op launched from EX this cycle.
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse).
- PCwrite  out  1  PC load enable.
- IF_IDwrite  out  1  IF/ID register write enable.
- IF_IDflush  out  1  clear IF/ID to NOP.
- ID_EXbubble  out  1  load NOP into ID/EX.
- EX_hold  out  1  freeze ID/EX and the EX stage.
- EX_MEMbubble  out  1  load NOP into EX/MEM.
- hazard  out  1  load-use stall active this cycle.
- mc_error  out  1  sticky: multi-cycle timeout occurred.
- stall_cnt  out  CNT_W  saturating count of cycles with PCwrite=0 (excluding reset).

Behaviour:
- States: RUN, FLUSH, MC_BUSY. State, flush counter, timeout counter, mc_error and stall_cnt are registered.
- Outputs are combinational decodes of current state plus current inputs, so a stall takes effect in the same cycle as the hazard.
- load_use = EX_memread & ((EX_rt==ID_rs) | (EX_rt==ID_rt)).
- Reset (rst=1, any state, takes priority over everything):
  - next state RUN; counters cleared; mc_error=0; stall_cnt=0.
  - Outputs during the reset cycle: PCwrite=0, IF_IDwrite=0, IF_IDflush=1, ID_EXbubble=1, EX_hold=0, EX_MEMbubble=1, hazard=0.
- RUN, default outputs: PCwrite=1, IF_IDwrite=1, all flush/bubble/hold/hazard signals 0.
- RUN, priority branch_taken > mc_start > load_use:
  - branch_taken: IF_IDflush=1, ID_EXbubble=1, PCwrite=1. Next state FLUSH if FLUSH_CYCLES>1 (flush count = FLUSH_CYCLES-1), else RUN. mc_start and load_use are ignored that cycle.
  - mc_start: EX_hold=1, EX_MEMbubble=1, PCwrite=0, IF_IDwrite=0. Next state MC_BUSY; timeout counter cleared.
  - load_use: hazard=1, PCwrite=0, IF_IDwrite=0, ID_EXbubble=1. Stays in RUN. The stall is exactly one cycle per detection; it repeats only if load_use is still true next cycle.
- FLUSH:
  - Outputs: IF_IDflush=1, ID_EXbubble=1, PCwrite=1, IF_IDwrite=1.
  - Flush counter decrements each cycle; exit to RUN when the count reaches 1.
  - branch_taken, mc_start and load_use are ignored (squashed instructions).
- MC_BUSY:
  - Outputs: EX_hold=1, EX_MEMbubble=1, PCwrite=0, IF_IDwrite=0. load_use and branch_taken are ignored.
  - mc_done=1: outputs revert to RUN defaults in that same cycle (hold released); next state RUN.
  - Timeout counter increments each cycle without mc_done. When it reaches MC_TIMEOUT-1: set mc_error, release exactly as for mc_done, next state RUN.
  - If mc_done and timeout coincide, mc_done wins and mc_error is not set.
- mc_done while in RUN or FLUSH is ignored.
- stall_cnt: increments when rst=0 and PCwrite=0; saturates at 2^CNT_W-1 with no wrap.
- mc_error is cleared only by rst.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, inputs 0 → PCwrite=0, IF_IDflush=1, EX_MEMbubble=1 during reset. After release: PCwrite=1, IF_IDwrite=1, stall_cnt=0.
- Load-use cases:
  - EX_memread=1, EX_rt=4, ID_rt=4, ID_rs=2 → hazard=1, PCwrite=0, ID_EXbubble=1 for 1 cycle; stall_cnt=1.
  - EX_rt=1, ID_rs=3, ID_rt=2 → no stall.
  - EX_rt=0, ID_rs=0 → stall (R0 not special).
- Branch: branch_taken=1 with a simultaneous load_use=1 → IF_IDflush=1 for exactly 2 cycles, hazard=0, PCwrite=1 throughout.
- Multi-cycle: mc_start pulse, mc_done asserted 5 cycles later → EX_hold=1 for 5 cycles, released in the mc_done cycle; stall_cnt=5.
- Timeout: mc_start, no mc_done → release after MC_TIMEOUT=32 cycles, mc_error=1 and sticky. Variant: mc_done on the 32nd cycle → mc_error stays 0.
- Reset mid-MC_BUSY and saturation:
  - rst asserted in the 3rd busy cycle → RUN next cycle, EX_hold=0, stall_cnt=0.
  - With CNT_W=2 and 5 stall cycles → stall_cnt=3.
